pipeline_hazard_controller: RTL and testbench

Central stall/flush sequencer for the 5-stage pipeline. It drives write-enables and flush (bubble) controls for the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It resolves three hazard classes:
- load-use data hazards, by stalling one cycle;
- multi-cycle data-memory accesses, by freezing the pipeline via an FSM;
- taken branches/jumps resolved at EX/MEM, by redirecting and flushing.

It also keeps saturating stall/flush performance counters and a sticky memory-timeout flag.

---
 rtl/pipeline_hazard_controller.sv | 197 +++++++++++++++++++
 tb/tb_pipeline_hazard_controller.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_controller.sv
// Purpose: stall/flush sequencer for the 5-stage pipeline (load-use, multi-cycle dmem, EX/MEM redirect).
// Latency: all controls are combinational from state + inputs; counters and the timeout flag update on the next edge.
// Backpressure: a busy data memory freezes PC, IF/ID, ID/EX and EX/MEM and bubbles MEM/WB until ready or timeout.
//
// Ports:
//   clk_i, reset_i (synchronous, active-low)
//   id_*          : source registers of the instruction in ID and whether it reads them
//   de_*          : load flag and destination of the instruction in EX
//   em_*          : load/store/taken-branch flags of the instruction in EX/MEM
//   dmem_ready_i  : data memory completes the access this cycle
//   *_write_o     : pipeline register / PC enables
//   *_flush_o     : pipeline register bubble loads (a flush wins over the enable)
//   pc_redirect_o : take the EX/MEM target as the next PC
//   stall_count_o, flush_count_o : saturating performance counters
//   mem_timeout_o : sticky flag, set when a memory wait is aborted
module pipeline_hazard_controller #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [4:0]       id_rs1_i,
  input  logic [4:0]       id_rs2_i,
  input  logic             id_uses_rs1_i,
  input  logic             id_uses_rs2_i,
  input  logic             de_mem_read_i,
  input  logic [4:0]       de_write_reg_i,
  input  logic             em_mem_read_i,
  input  logic             em_mem_write_i,
  input  logic             em_pc_select_i,
  input  logic             dmem_ready_i,
  output logic             pc_write_o,
  output logic             pc_redirect_o,
  output logic             fd_write_o,
  output logic             fd_flush_o,
  output logic             de_write_o,
  output logic             de_flush_o,
  output logic             em_write_o,
  output logic             em_flush_o,
  output logic             mw_flush_o,
  output logic [CNT_W-1:0] stall_count_o,
  output logic [CNT_W-1:0] flush_count_o,
  output logic             mem_timeout_o
);

  localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);

  localparam logic [WAIT_W-1:0] WAIT_ZERO  = '0;
  localparam logic [WAIT_W-1:0] WAIT_ONE   = WAIT_W'(1);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_MAX    = '1;

  typedef enum logic [0:0] {
    ST_RUN      = 1'b0,
    ST_MEM_WAIT = 1'b1
  } state_t;

  state_t            state_q,       state_d;
  logic [WAIT_W-1:0] wait_cnt_q,    wait_cnt_d;
  logic [CNT_W-1:0]  stall_count_q, stall_count_d;
  logic [CNT_W-1:0]  flush_count_q, flush_count_d;
  logic              mem_timeout_q, mem_timeout_d;

  logic mem_busy;
  logic load_use;
  logic freeze;
  logic resolve;

  assign mem_busy = (em_mem_read_i | em_mem_write_i) & ~dmem_ready_i;

  // x0 is never really written, so a load targeting it cannot create a dependency.
  assign load_use = de_mem_read_i && (de_write_reg_i != 5'd0) &&
                    ((id_uses_rs1_i && (id_rs1_i == de_write_reg_i)) ||
                     (id_uses_rs2_i && (id_rs2_i == de_write_reg_i)));

  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    mem_timeout_d = mem_timeout_q;
    freeze        = 1'b0;
    resolve       = 1'b0;

    pc_write_o    = 1'b1;
    pc_redirect_o = 1'b0;
    fd_write_o    = 1'b1;
    fd_flush_o    = 1'b0;
    de_write_o    = 1'b1;
    de_flush_o    = 1'b0;
    em_write_o    = 1'b1;
    em_flush_o    = 1'b0;
    mw_flush_o    = 1'b0;

    case (state_q)
      ST_RUN: begin
        if (mem_busy) begin
          // The freeze starts in the very cycle the busy access is seen.
          freeze     = 1'b1;
          state_d    = ST_MEM_WAIT;
          wait_cnt_d = WAIT_ONE;
        end else begin
          resolve = 1'b1;
        end
      end
      ST_MEM_WAIT: begin
        if (dmem_ready_i) begin
          // Completion cycle behaves like an ordinary RUN cycle.
          resolve    = 1'b1;
          state_d    = ST_RUN;
          wait_cnt_d = WAIT_ZERO;
        end else if (wait_cnt_q < WAIT_LIMIT) begin
          freeze     = 1'b1;
          wait_cnt_d = wait_cnt_q + WAIT_ONE;
        end else begin
          // Abort: let the pipe move, kill the stuck access in EX/MEM and
          // keep it from reaching write-back.
          em_flush_o    = 1'b1;
          mw_flush_o    = 1'b1;
          mem_timeout_d = 1'b1;
          state_d       = ST_RUN;
          wait_cnt_d    = WAIT_ZERO;
        end
      end
      default: begin
        state_d    = ST_RUN;
        wait_cnt_d = WAIT_ZERO;
      end
    endcase

    if (freeze) begin
      pc_write_o = 1'b0;
      fd_write_o = 1'b0;
      de_write_o = 1'b0;
      em_write_o = 1'b0;
      mw_flush_o = 1'b1;
    end

    if (resolve) begin
      if (em_pc_select_i) begin
        // Redirect squashes the three younger instructions; load-use is moot.
        pc_redirect_o = 1'b1;
        pc_write_o    = 1'b1;
        fd_flush_o    = 1'b1;
        de_flush_o    = 1'b1;
        em_flush_o    = 1'b1;
      end else if (load_use) begin
        // Single bubble: the load has moved past EX by the next cycle.
        pc_write_o = 1'b0;
        fd_write_o = 1'b0;
        de_flush_o = 1'b1;
      end
    end

    if (!reset_i) begin
      pc_write_o    = 1'b0;
      pc_redirect_o = 1'b0;
      fd_write_o    = 1'b0;
      fd_flush_o    = 1'b1;
      de_write_o    = 1'b0;
      de_flush_o    = 1'b1;
      em_write_o    = 1'b0;
      em_flush_o    = 1'b1;
      mw_flush_o    = 1'b1;
    end

    stall_count_d = stall_count_q;
    if (!pc_write_o && (stall_count_q != CNT_MAX)) begin
      stall_count_d = stall_count_q + CNT_ONE;
    end

    flush_count_d = flush_count_q;
    if (pc_redirect_o && (flush_count_q != CNT_MAX)) begin
      flush_count_d = flush_count_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q       <= ST_RUN;
      wait_cnt_q    <= WAIT_ZERO;
      stall_count_q <= '0;
      flush_count_q <= '0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      stall_count_q <= stall_count_d;
      flush_count_q <= flush_count_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

  assign stall_count_o = stall_count_q;
  assign flush_count_o = flush_count_q;
  assign mem_timeout_o = mem_timeout_q;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Purpose: directed self-checking bench for pipeline_hazard_controller.
// Latency: inputs driven 1 time unit after the rising edge, outputs sampled 1 unit later.
// Backpressure: dmem_ready_i is driven directly to exercise freeze, completion and timeout.
module tb_pipeline_hazard_controller;

  localparam int unsigned MEM_TIMEOUT = 4;
  localparam int unsigned CNT_W       = 4;

  // Control vector order: pc_write, pc_redirect, fd_write, fd_flush,
  // de_write, de_flush, em_write, em_flush, mw_flush
  localparam logic [8:0] V_NORMAL  = 9'b1_0_1_0_1_0_1_0_0;
  localparam logic [8:0] V_LOADUSE = 9'b0_0_0_0_1_1_1_0_0;
  localparam logic [8:0] V_REDIR   = 9'b1_1_1_1_1_1_1_1_0;
  localparam logic [8:0] V_FREEZE  = 9'b0_0_0_0_0_0_0_0_1;
  localparam logic [8:0] V_ABORT   = 9'b1_0_1_0_1_0_1_1_1;
  localparam logic [8:0] V_RESET   = 9'b0_0_0_1_0_1_0_1_1;

  logic clk_i = 1'b0;
  logic reset_i;
  logic [4:0] id_rs1_i, id_rs2_i, de_write_reg_i;
  logic id_uses_rs1_i, id_uses_rs2_i, de_mem_read_i;
  logic em_mem_read_i, em_mem_write_i, em_pc_select_i, dmem_ready_i;
  logic pc_write_o, pc_redirect_o, fd_write_o, fd_flush_o;
  logic de_write_o, de_flush_o, em_write_o, em_flush_o, mw_flush_o;
  logic [CNT_W-1:0] stall_count_o, flush_count_o;
  logic mem_timeout_o;
  logic [8:0] ctl;

  int passed = 0;
  int total  = 0;

  always #5 clk_i = ~clk_i;

  pipeline_hazard_controller #(
    .MEM_TIMEOUT(MEM_TIMEOUT),
    .CNT_W      (CNT_W)
  ) dut (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .id_rs1_i      (id_rs1_i),
    .id_rs2_i      (id_rs2_i),
    .id_uses_rs1_i (id_uses_rs1_i),
    .id_uses_rs2_i (id_uses_rs2_i),
    .de_mem_read_i (de_mem_read_i),
    .de_write_reg_i(de_write_reg_i),
    .em_mem_read_i (em_mem_read_i),
    .em_mem_write_i(em_mem_write_i),
    .em_pc_select_i(em_pc_select_i),
    .dmem_ready_i  (dmem_ready_i),
    .pc_write_o    (pc_write_o),
    .pc_redirect_o (pc_redirect_o),
    .fd_write_o    (fd_write_o),
    .fd_flush_o    (fd_flush_o),
    .de_write_o    (de_write_o),
    .de_flush_o    (de_flush_o),
    .em_write_o    (em_write_o),
    .em_flush_o    (em_flush_o),
    .mw_flush_o    (mw_flush_o),
    .stall_count_o (stall_count_o),
    .flush_count_o (flush_count_o),
    .mem_timeout_o (mem_timeout_o)
  );

  assign ctl = {pc_write_o, pc_redirect_o, fd_write_o, fd_flush_o,
                de_write_o, de_flush_o, em_write_o, em_flush_o, mw_flush_o};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic chk_ctl(input string tag, input logic [8:0] exp);
    chk(tag, {23'd0, ctl}, {23'd0, exp});
  endtask

  task automatic chk_cnt(input string tag, input logic [CNT_W-1:0] stall_exp,
                         input logic [CNT_W-1:0] flush_exp, input logic to_exp);
    chk({tag, "_stall"}, {{(32-CNT_W){1'b0}}, stall_count_o}, {{(32-CNT_W){1'b0}}, stall_exp});
    chk({tag, "_flush"}, {{(32-CNT_W){1'b0}}, flush_count_o}, {{(32-CNT_W){1'b0}}, flush_exp});
    chk({tag, "_tmo"}, {31'd0, mem_timeout_o}, {31'd0, to_exp});
  endtask

  // Advance past the next rising edge, then allow 1 unit before driving.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    id_rs1_i       = 5'd0;
    id_rs2_i       = 5'd0;
    id_uses_rs1_i  = 1'b0;
    id_uses_rs2_i  = 1'b0;
    de_mem_read_i  = 1'b0;
    de_write_reg_i = 5'd0;
    em_mem_read_i  = 1'b0;
    em_mem_write_i = 1'b0;
    em_pc_select_i = 1'b0;
    dmem_ready_i   = 1'b0;
  endtask

  task automatic set_load_use(input logic [4:0] rd, input logic [4:0] rs2);
    de_mem_read_i  = 1'b1;
    de_write_reg_i = rd;
    id_rs2_i       = rs2;
    id_uses_rs2_i  = 1'b1;
    id_rs1_i       = 5'd3;
    id_uses_rs1_i  = 1'b1;
  endtask

  initial begin
    reset_i = 1'b0;
    idle_inputs();
    #2;
    chk_ctl("reset_force", V_RESET);
    tick();
    tick();
    reset_i = 1'b1;
    #1;
    chk_ctl("after_reset", V_NORMAL);
    chk_cnt("after_reset", 4'd0, 4'd0, 1'b0);

    // Load-use on rs2
    set_load_use(5'd5, 5'd5);
    #1 chk_ctl("lu_rs2", V_LOADUSE);
    tick();
    de_mem_read_i = 1'b0;
    #1 chk_ctl("lu_rs2_next", V_NORMAL);
    chk_cnt("lu_rs2", 4'd1, 4'd0, 1'b0);

    // Load-use on rs1
    idle_inputs();
    de_mem_read_i = 1'b1; de_write_reg_i = 5'd7; id_rs1_i = 5'd7; id_uses_rs1_i = 1'b1;
    #1 chk_ctl("lu_rs1", V_LOADUSE);
    tick();
    // Same match but rs1 not read: no stall
    id_uses_rs1_i = 1'b0;
    #1 chk_ctl("lu_unused_src", V_NORMAL);
    tick();
    // Load into x0: no stall
    idle_inputs();
    set_load_use(5'd0, 5'd0);
    #1 chk_ctl("lu_x0", V_NORMAL);
    tick();
    idle_inputs();
    #1 chk_cnt("lu_x0", 4'd2, 4'd0, 1'b0);

    // Redirect with a coincident load-use
    set_load_use(5'd5, 5'd5);
    em_pc_select_i = 1'b1;
    #1 chk_ctl("redirect", V_REDIR);
    tick();
    idle_inputs();
    #1 chk_ctl("redirect_next", V_NORMAL);
    chk_cnt("redirect", 4'd2, 4'd1, 1'b0);

    // Multi-cycle load: 3 busy cycles then ready
    em_mem_read_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 chk_ctl($sformatf("mem_busy%0d", i), V_FREEZE);
      tick();
    end
    dmem_ready_i = 1'b1;
    #1 chk_ctl("mem_ready", V_NORMAL);
    tick();
    idle_inputs();
    #1 chk_ctl("mem_back_run", V_NORMAL);
    chk_cnt("mem", 4'd5, 4'd1, 1'b0);

    // Store with pending redirect, ready after 2 cycles
    em_mem_write_i = 1'b1; em_pc_select_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1 chk_ctl($sformatf("wr_busy%0d", i), V_FREEZE);
      tick();
    end
    dmem_ready_i = 1'b1;
    #1 chk_ctl("wr_ready_redirect", V_REDIR);
    tick();
    idle_inputs();
    #1 chk_ctl("wr_back_run", V_NORMAL);
    chk_cnt("wr_redirect", 4'd7, 4'd2, 1'b0);

    // Timeout: 4 frozen cycles then an abort cycle
    em_mem_read_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1 chk_ctl($sformatf("tmo_busy%0d", i), V_FREEZE);
      tick();
    end
    #1 chk_ctl("tmo_abort", V_ABORT);
    tick();
    idle_inputs();
    #1 chk_ctl("tmo_back_run", V_NORMAL);
    chk_cnt("tmo", 4'd11, 4'd2, 1'b1);
    tick();
    tick();
    chk("tmo_sticky", {31'd0, mem_timeout_o}, 32'd1);

    // Stall counter saturation: 6 load-use cycles from 11 must stop at 15
    set_load_use(5'd9, 5'd9);
    for (int i = 0; i < 6; i++) tick();
    idle_inputs();
    #1 chk_cnt("saturate", 4'd15, 4'd2, 1'b1);

    // Reset in the middle of a memory wait
    em_mem_read_i = 1'b1;
    tick();
    tick();
    reset_i = 1'b0;
    #1 chk_ctl("rst_midwait", V_RESET);
    tick();
    chk_ctl("rst_midwait_hold", V_RESET);
    em_mem_read_i = 1'b0;
    reset_i = 1'b1;
    #1 chk_ctl("rst_release_run", V_NORMAL);
    chk_cnt("rst_release", 4'd0, 4'd0, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
